adma_atx_cpl: RTL and testbench
===============================

ADMA_ATX_CPL -- requirements
Module: adma_atx_cpl

Interface
REQ-001 SHALL have parameter DMA_CHN_NUM, default 4, number of DMA channels.
REQ-002 SHALL have parameter MST_ID_W, default 5, AXI ID width.
REQ-003 SHALL have parameter ATX_NUM_OSTD, default DMA_CHN_NUM, outstanding-table depth.
REQ-004 SHALL have parameter DMA_CHN_NUM_W, default $clog2(DMA_CHN_NUM), channel-index width; not user-set.
REQ-005 SHALL have parameter OSTD_CNT_W, default $clog2(ATX_NUM_OSTD+1), occupancy width; not user-set.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 atx_chn_id  input  DMA_CHN_NUM_W  channel owning the issued write transaction.
REQ-009 atx_awid  input  MST_ID_W  AWID of the issued transaction.
REQ-010 atx_vld  input  1  issued-transaction record valid.
REQ-011 atx_rdy  output  1  record accepted when atx_vld&&atx_rdy.
REQ-012 m_bid  input  MST_ID_W  AXI write-response ID.
REQ-013 m_bresp  input  2  AXI write-response status.
REQ-014 m_bvalid  input  1  AXI B valid.
REQ-015 m_bready  output  1  AXI B ready.
REQ-016 atx_done  output  1 x DMA_CHN_NUM (unpacked array)  per-channel one-cycle completion pulse.
REQ-017 atx_slverr  output  1  one-cycle pulse: completed response had bresp!=2'b00.
REQ-018 atx_unexp_bid  output  1  one-cycle pulse: B accepted with no matching entry.
REQ-019 ostd_cnt  output  OSTD_CNT_W  entries currently outstanding.

Function
REQ-020 SHALL hold ATX_NUM_OSTD entries {vld, id, chn}, kept compacted in age order, index 0 oldest.
REQ-021 atx_rdy SHALL equal (ostd_cnt < ATX_NUM_OSTD), from registered count only; no same-cycle pop bypass.
REQ-022 Push: on atx_vld&&atx_rdy, record SHALL be written at index ostd_cnt (after any same-cycle pop compaction) and be visible next cycle.
REQ-023 m_bready SHALL be 1 whenever rst_n is high; every B beat is accepted in the cycle it is valid.
REQ-024 Match: on m_bvalid&&m_bready, SHALL select the lowest-index valid entry whose id==m_bid; a record pushed in the same cycle SHALL NOT be matchable.
REQ-025 On match, entry SHALL be removed, younger entries shift down one index, ostd_cnt decrements.
REQ-026 On match at cycle t, atx_done[chn] SHALL be 1 in cycle t+1 only; all other atx_done bits 0.
REQ-027 On match with bresp!=0, atx_slverr SHALL pulse in t+1 alongside atx_done; atx_done still pulses.
REQ-028 On no match (including empty table), atx_unexp_bid SHALL pulse in t+1, table and count unchanged, no atx_done.
REQ-029 Simultaneous push and matched pop SHALL leave ostd_cnt unchanged, preserving age order (new record youngest).
REQ-030 Same-ID completions SHALL retire in issue order; different IDs MAY retire out of order.
REQ-031 ostd_cnt SHALL never exceed ATX_NUM_OSTD nor underflow.

Reset
REQ-032 While rst_n low: all entries invalid, ostd_cnt=0, atx_rdy=0, m_bready=0, atx_done all 0, atx_slverr=0, atx_unexp_bid=0.
REQ-033 Reset assertion mid-operation SHALL discard all outstanding entries immediately; no done pulses for them afterward.
REQ-034 First cycle after rst_n deasserts: atx_rdy=1, m_bready=1.

Verification
REQ-035 Push {chn=2,id=5}; next cycle B {bid=5,bresp=0} -> atx_done[2]=1 one cycle later for one cycle, ostd_cnt 1->0.
REQ-036 Push 4 records (OSTD=4) -> atx_rdy=0, 5th atx_vld held not accepted; B for any -> atx_rdy=1 next cycle.
REQ-037 Push {chn0,id3},{chn1,id3},{chn2,id7}; B bid=7 then bid=3 twice -> done order chn2, chn0, chn1.
REQ-038 Empty table, B bid=9 -> atx_unexp_bid pulse, ostd_cnt stays 0, no atx_done.
REQ-039 Table full, same cycle push {chn3,id1} + B matching oldest -> push not accepted (atx_rdy=0), pop occurs, count 4->3.
REQ-040 B bresp=2'b10 on match chn1 -> atx_done[1] and atx_slverr both pulse; rst_n low with 2 outstanding -> count 0, no later done.

Source files
------------

// File: rtl/adma_atx_cpl_if.sv
// rtl/adma_atx_cpl_if.sv - issued-transaction record and AXI B-channel bundle for adma_atx_cpl
// Ports (signals):
//   atx_chn_id / atx_awid / atx_vld / atx_rdy : issued write record handshake
//   m_bid / m_bresp / m_bvalid / m_bready     : AXI write-response channel
// Modports: master drives records and B beats, slave is the completion tracker.
interface adma_atx_cpl_if #(
    parameter int DMA_CHN_NUM = 4,
    parameter int MST_ID_W    = 5
) ();
    localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM);

    logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
    logic [MST_ID_W-1:0]      atx_awid;
    logic                     atx_vld;
    logic                     atx_rdy;
    logic [MST_ID_W-1:0]      m_bid;
    logic [1:0]               m_bresp;
    logic                     m_bvalid;
    logic                     m_bready;

    modport master (
        output atx_chn_id, atx_awid, atx_vld, m_bid, m_bresp, m_bvalid,
        input  atx_rdy, m_bready
    );

    modport slave (
        input  atx_chn_id, atx_awid, atx_vld, m_bid, m_bresp, m_bvalid,
        output atx_rdy, m_bready
    );
endinterface

// File: rtl/adma_atx_cpl.sv
// rtl/adma_atx_cpl.sv - outstanding write-transaction table matching AXI B responses to DMA channels
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : issued record push (atx_*) and AXI B channel (m_b*)
//   atx_done[]     : per-channel one-cycle completion pulse
//   atx_slverr     : one-cycle pulse, completed response carried an error status
//   atx_unexp_bid  : one-cycle pulse, B beat matched no outstanding entry
//   ostd_cnt       : number of outstanding entries
module adma_atx_cpl #(
    parameter int  DMA_CHN_NUM   = 4,
    parameter int  MST_ID_W      = 5,
    parameter int  ATX_NUM_OSTD  = DMA_CHN_NUM,
    localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
    localparam int OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adma_atx_cpl_if.slave         bus,
    output logic                  atx_done [DMA_CHN_NUM],
    output logic                  atx_slverr,
    output logic                  atx_unexp_bid,
    output logic [OSTD_CNT_W-1:0] ostd_cnt
);

    // Table is kept compacted: index 0 is the oldest, entries [0, ostd_cnt) are valid.
    logic                     t_vld [ATX_NUM_OSTD];
    logic [MST_ID_W-1:0]      t_id  [ATX_NUM_OSTD];
    logic [DMA_CHN_NUM_W-1:0] t_chn [ATX_NUM_OSTD];

    // One extra invalid slot so the shift-down of the youngest entry needs no special case.
    logic                     x_vld [ATX_NUM_OSTD+1];
    logic [MST_ID_W-1:0]      x_id  [ATX_NUM_OSTD+1];
    logic [DMA_CHN_NUM_W-1:0] x_chn [ATX_NUM_OSTD+1];

    logic                     n_vld [ATX_NUM_OSTD];
    logic [MST_ID_W-1:0]      n_id  [ATX_NUM_OSTD];
    logic [DMA_CHN_NUM_W-1:0] n_chn [ATX_NUM_OSTD];

    logic                     push;
    logic                     b_acc;
    logic                     hit;
    logic [DMA_CHN_NUM_W-1:0] hit_chn;
    logic [OSTD_CNT_W-1:0]    push_idx;
    logic [OSTD_CNT_W-1:0]    cnt_nxt;
    logic [DMA_CHN_NUM-1:0]   done_q;
    logic [DMA_CHN_NUM-1:0]   done_nxt;
    logic                     slverr_nxt;
    logic                     unexp_nxt;

    // Both ready terms are held low during reset; otherwise B is always accepted and
    // record acceptance depends only on the registered count (no pop bypass).
    assign bus.m_bready = rst_n;
    assign bus.atx_rdy  = rst_n && (ostd_cnt < OSTD_CNT_W'(ATX_NUM_OSTD));
    assign push         = bus.atx_vld && bus.atx_rdy;
    assign b_acc        = bus.m_bvalid && bus.m_bready;

    always_comb begin
        for (int i = 0; i < ATX_NUM_OSTD; i++) begin
            x_vld[i] = t_vld[i];
            x_id[i]  = t_id[i];
            x_chn[i] = t_chn[i];
        end
        x_vld[ATX_NUM_OSTD] = 1'b0;
        x_id[ATX_NUM_OSTD]  = '0;
        x_chn[ATX_NUM_OSTD] = '0;

        hit     = 1'b0;
        hit_chn = '0;
        // The match search only sees the registered table, so a record pushed this
        // cycle cannot complete in the same cycle. Once hit is set, the matched slot
        // and every younger slot take the next-younger entry.
        for (int i = 0; i < ATX_NUM_OSTD; i++) begin
            if (b_acc && !hit && t_vld[i] && (t_id[i] == bus.m_bid)) begin
                hit     = 1'b1;
                hit_chn = t_chn[i];
            end
            if (hit) begin
                n_vld[i] = x_vld[i+1];
                n_id[i]  = x_id[i+1];
                n_chn[i] = x_chn[i+1];
            end else begin
                n_vld[i] = x_vld[i];
                n_id[i]  = x_id[i];
                n_chn[i] = x_chn[i];
            end
        end

        // New record lands just past the youngest surviving entry.
        push_idx = ostd_cnt - OSTD_CNT_W'(hit);
        for (int i = 0; i < ATX_NUM_OSTD; i++) begin
            if (push && (OSTD_CNT_W'(i) == push_idx)) begin
                n_vld[i] = 1'b1;
                n_id[i]  = bus.atx_awid;
                n_chn[i] = bus.atx_chn_id;
            end
        end

        cnt_nxt  = ostd_cnt - OSTD_CNT_W'(hit) + OSTD_CNT_W'(push);

        done_nxt = '0;
        if (hit) begin
            done_nxt[hit_chn] = 1'b1;
        end
        slverr_nxt = hit && (bus.m_bresp != 2'b00);
        unexp_nxt  = b_acc && !hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ATX_NUM_OSTD; i++) begin
                t_vld[i] <= 1'b0;
                t_id[i]  <= '0;
                t_chn[i] <= '0;
            end
            ostd_cnt      <= '0;
            done_q        <= '0;
            atx_slverr    <= 1'b0;
            atx_unexp_bid <= 1'b0;
        end else begin
            for (int i = 0; i < ATX_NUM_OSTD; i++) begin
                t_vld[i] <= n_vld[i];
                t_id[i]  <= n_id[i];
                t_chn[i] <= n_chn[i];
            end
            ostd_cnt      <= cnt_nxt;
            done_q        <= done_nxt;
            atx_slverr    <= slverr_nxt;
            atx_unexp_bid <= unexp_nxt;
        end
    end

    always_comb begin
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            atx_done[c] = done_q[c];
        end
    end

endmodule

// File: tb/tb_adma_atx_cpl.sv
// tb/tb_adma_atx_cpl.sv - scoreboard bench for adma_atx_cpl
module tb_adma_atx_cpl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       atx_done [4];
    logic       atx_slverr;
    logic       atx_unexp_bid;
    logic [2:0] ostd_cnt;

    adma_atx_cpl_if #(.DMA_CHN_NUM(4), .MST_ID_W(5)) bus ();

    adma_atx_cpl #(.DMA_CHN_NUM(4), .MST_ID_W(5), .ATX_NUM_OSTD(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .atx_done      (atx_done),
        .atx_slverr    (atx_slverr),
        .atx_unexp_bid (atx_unexp_bid),
        .ostd_cnt      (ostd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id;
        logic [1:0] chn;
    } rec_t;

    typedef struct {
        logic [5:0] val;   // {unexp, slverr, done[3:0]}
        int         cyc;
    } exp_t;

    rec_t mdl [$];
    exp_t exp_q [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [5:0] obs_vec();
        return {atx_unexp_bid, atx_slverr, atx_done[3], atx_done[2], atx_done[1], atx_done[0]};
    endfunction

    // Every pulse must match the head of the scoreboard, in the predicted cycle.
    exp_t       mon_e;
    logic [5:0] mon_obs;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_obs = obs_vec();
            if (mon_obs != 6'd0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 32'(mon_obs), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse", 32'(mon_obs), 32'(mon_e.val));
                    check("pulse_cyc", cyc, mon_e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("missing_pulse", 32'd0, 32'(exp_q[0].val));
                void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of stimulus (called at posedge+1), predict its outcome, advance.
    task automatic step(input logic pv, input logic [1:0] pc, input logic [4:0] pid,
                        input logic bv, input logic [4:0] bid, input logic [1:0] br);
        exp_t e;
        int   hit;
        logic rdy_exp;
        bus.atx_vld    = pv;
        bus.atx_chn_id = pc;
        bus.atx_awid   = pid;
        bus.m_bvalid   = bv;
        bus.m_bid      = bid;
        bus.m_bresp    = br;
        rdy_exp = (mdl.size() < 4);
        check("ostd_cnt", 32'(ostd_cnt), mdl.size());
        check("atx_rdy", 32'(bus.atx_rdy), 32'(rdy_exp));
        check("m_bready", 32'(bus.m_bready), 32'd1);
        if (bv) begin
            hit = -1;
            for (int i = 0; i < mdl.size(); i++) begin
                if (hit < 0 && mdl[i].id == bid) hit = i;
            end
            if (hit >= 0) begin
                e.val = {1'b0, br != 2'b00, 4'b0001 << mdl[hit].chn};
                mdl.delete(hit);
            end else begin
                e.val = 6'b100000;
            end
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        if (pv && rdy_exp) mdl.push_back('{id: pid, chn: pc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    endtask

    task automatic push_rec(input logic [1:0] c, input logic [4:0] id);
        step(1'b1, c, id, 1'b0, 5'd0, 2'd0);
    endtask

    task automatic resp(input logic [4:0] id, input logic [1:0] br);
        step(1'b0, 2'd0, 5'd0, 1'b1, id, br);
    endtask

    task automatic reset_checks();
        check("rst_cnt", 32'(ostd_cnt), 32'd0);
        check("rst_rdy", 32'(bus.atx_rdy), 32'd0);
        check("rst_bready", 32'(bus.m_bready), 32'd0);
        check("rst_outs", 32'(obs_vec()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.atx_vld = 1'b0; bus.atx_chn_id = '0; bus.atx_awid = '0;
        bus.m_bvalid = 1'b0; bus.m_bid = '0; bus.m_bresp = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", 32'(bus.atx_rdy), 32'd1);
        check("post_rst_bready", 32'(bus.m_bready), 32'd1);
        @(posedge clk);
        #1;

        // Single push then matching response.
        push_rec(2'd2, 5'd5);
        resp(5'd5, 2'b00);
        idle(2);

        // Fill the table; held 5th record waits until a response frees a slot.
        for (int i = 0; i < 4; i++) push_rec(2'(i), 5'(10 + i));
        step(1'b1, 2'd3, 5'd1, 1'b0, 5'd0, 2'd0);
        step(1'b1, 2'd3, 5'd1, 1'b1, 5'd12, 2'd0);
        step(1'b1, 2'd3, 5'd1, 1'b0, 5'd0, 2'd0);
        idle(1);
        resp(5'd10, 2'b00); resp(5'd11, 2'b00); resp(5'd13, 2'b00); resp(5'd1, 2'b00);
        idle(2);

        // Same-ID retire in order, different ID out of order.
        push_rec(2'd0, 5'd3); push_rec(2'd1, 5'd3); push_rec(2'd2, 5'd7);
        resp(5'd7, 2'b00); resp(5'd3, 2'b00); resp(5'd3, 2'b00);
        idle(2);

        // Unexpected ID on empty table.
        resp(5'd9, 2'b00);
        idle(2);

        // Full table: push blocked while oldest retires in the same cycle.
        for (int i = 0; i < 4; i++) push_rec(2'(i), 5'(20 + i));
        step(1'b1, 2'd3, 5'd1, 1'b1, 5'd20, 2'd0);
        idle(1);
        resp(5'd21, 2'b00); resp(5'd22, 2'b00); resp(5'd23, 2'b00);
        idle(2);

        // Push and matched pop together keeps count and age order.
        push_rec(2'd0, 5'd4); push_rec(2'd1, 5'd6);
        step(1'b1, 2'd2, 5'd4, 1'b1, 5'd4, 2'd0);
        resp(5'd4, 2'b00); resp(5'd6, 2'b00);
        idle(2);

        // Error status still completes, then reset mid-operation.
        push_rec(2'd1, 5'd8);
        resp(5'd8, 2'b10);
        push_rec(2'd0, 5'd14); push_rec(2'd3, 5'd15);
        idle(2);
        rst_n = 1'b0;
        mdl.delete();
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        resp(5'd14, 2'b00);
        resp(5'd15, 2'b00);
        idle(2);

        // Random traffic with a small ID space to exercise collisions.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 8 && mdl.size() > 0; n++) resp(mdl[0].id, 2'b00);
        idle(3);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("final_cnt", 32'(ostd_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
